// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared defaults, id width helper and response type for the adder scheduler
package adder_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CNT_W   = 8;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_w(DEF_NUM_REQ);

  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_WIDTH-1:0] s;
    logic                 overflow;
  } add_rsp_t;

endpackage

// File: rtl/add_ovf_unit.sv
// rtl/add_ovf_unit.sv - combinational two's-complement add with signed overflow flag
module add_ovf_unit
  import adder_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             overflow
);

  // Carry-out is intentionally dropped; overflow comes from the sign bits alone.
  assign s        = a + b;
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) & (s[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin shared adder with one result slot and saturating overflow counter
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [id_w(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_s,
  output logic                       rsp_overflow,
  output logic [CNT_W-1:0]           ovf_count
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [ID_W-1:0]      ptr;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  logic [ID_W-1:0]      off;
  logic [ID_W:0]        sum;
  logic [ID_W-1:0]      grant_id;
  logic                 slot_free;
  logic                 grant;
  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     b_sel;
  logic [WIDTH-1:0]     add_s;
  logic                 add_ovf;

  assign slot_free = ~rsp_valid | rsp_ready;

  // Rotate so ptr sits at bit 0, find the lowest set bit, then map back.
  always_comb begin
    dbl   = {req_valid, req_valid} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = ID_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    grant_id = sum[ID_W-1:0];
    grant    = found & slot_free & resetn;
    req_ready = '0;
    if (grant) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  add_ovf_unit #(.WIDTH(WIDTH)) u_add (
    .a        (a_sel),
    .b        (b_sel),
    .s        (add_s),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_s        <= '0;
      rsp_overflow <= 1'b0;
      ovf_count    <= '0;
      ptr          <= '0;
    end else begin
      if (grant) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= grant_id;
        rsp_s        <= add_s;
        rsp_overflow <= add_ovf;
        ptr          <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready && rsp_overflow && (ovf_count != {CNT_W{1'b1}}))
        ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - directed self-checking bench for adder_rr_scheduler
module tb_adder_rr_scheduler;
  import adder_sched_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_ready;

  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_s;
  logic        rsp_overflow;
  logic [7:0]  ovf_count;

  logic [3:0]  sat_req_ready;
  logic        sat_rsp_valid;
  logic [1:0]  sat_rsp_id;
  logic [7:0]  sat_rsp_s;
  logic        sat_rsp_overflow;
  logic [1:0]  sat_ovf_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_rr_scheduler dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_s        (rsp_s),
    .rsp_overflow (rsp_overflow),
    .ovf_count    (ovf_count)
  );

  adder_rr_scheduler #(.CNT_W(2)) dut_sat (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (sat_req_ready),
    .rsp_valid    (sat_rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (sat_rsp_id),
    .rsp_s        (sat_rsp_s),
    .rsp_overflow (sat_rsp_overflow),
    .ovf_count    (sat_ovf_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  logic [7:0] va [4] = '{8'h70, 8'h90, 8'h70, 8'h90};
  logic [7:0] vb [4] = '{8'h70, 8'h90, 8'h90, 8'hFF};
  logic [7:0] vs [4] = '{8'hE0, 8'h20, 8'h00, 8'h8F};
  logic       vo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] rr_seq [6]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] skip_seq [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
  logic [1:0] sat_seq [5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  add_rsp_t exp_r;

  initial begin
    resetn    = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_s", rsp_s, 0);
    check("reset_rsp_ovf", rsp_overflow, 0);
    check("reset_ovf_count", ovf_count, 0);
    check("reset_req_ready", req_ready, 0);

    // Arithmetic through requester 0
    resetn    = 1'b1;
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      req_a[7:0] = va[k];
      req_b[7:0] = vb[k];
      #1;
      check("arith_req_ready", req_ready, 4'b0001);
      tick();
      exp_r = '{id: 2'd0, s: vs[k], overflow: vo[k]};
      check("arith_valid", rsp_valid, 1);
      check("arith_id", rsp_id, exp_r.id);
      check("arith_s", rsp_s, exp_r.s);
      check("arith_ovf", rsp_overflow, exp_r.overflow);
    end
    req_valid = 4'b0000;
    tick();
    check("drain_valid", rsp_valid, 0);
    check("drain_hold_s", rsp_s, 8'h8F);
    check("arith_ovf_count", ovf_count, 2);

    // Round robin with everyone requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i);
      req_b[i*8 +: 8] = 8'h10;
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    check("rr_first_ready", req_ready, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_valid", rsp_valid, 1);
      check("rr_id", rsp_id, rr_seq[k]);
      check("rr_s", rsp_s, 8'h10 + 8'(rr_seq[k]));
    end

    // Idle requesters are skipped, then req 0 joins after a grant to 3
    do_reset();
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("skip_id", rsp_id, skip_seq[k]);
    end
    req_valid = 4'b1011;
    #1;
    check("skip_join_ready", req_ready, 4'b0001);
    tick();
    check("skip_join_id", rsp_id, 0);

    // Backpressure: hold id 2 for five cycles
    do_reset();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    tick();
    tick();
    tick();
    check("bp_full_id", rsp_id, 2);
    rsp_ready = 1'b0;
    req_a[2*8 +: 8] = 8'h55;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_req_ready", req_ready, 0);
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 2);
      check("bp_s", rsp_s, 8'h12);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 4'b1000);
    tick();
    check("bp_refill_valid", rsp_valid, 1);
    check("bp_refill_id", rsp_id, 3);
    check("bp_refill_s", rsp_s, 8'h13);

    // Counter saturation: only consumed overflows count
    do_reset();
    req_valid  = 4'b0001;
    req_a[7:0] = 8'h80;
    req_b[7:0] = 8'h80;
    rsp_ready  = 1'b1;
    tick();
    check("sat_first_ovf", rsp_overflow, 1);
    rsp_ready = 1'b0;
    tick();
    tick();
    check("sat_unconsumed", sat_ovf_count, 0);
    check("sat_unconsumed_main", ovf_count, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sat_count", sat_ovf_count, sat_seq[k]);
      check("sat_count_main", ovf_count, k + 1);
    end
    check("sat_still_full", rsp_valid, 1);

    // Reset while full
    resetn = 1'b0;
    req_valid = 4'hF;
    #1;
    check("mid_reset_ready", req_ready, 0);
    tick();
    check("mid_reset_valid", rsp_valid, 0);
    check("mid_reset_count", ovf_count, 0);
    check("mid_reset_sat_count", sat_ovf_count, 0);
    resetn = 1'b1;
    #1;
    check("mid_reset_next_ready", req_ready, 4'b0001);
    tick();
    check("mid_reset_next_id", rsp_id, 0);
    check("mid_reset_next_valid", rsp_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
